// File: rtl/n101_spigpioport_sync.sv
// SPI controller to GPIO pad port: input synchronisers, per-lane bus-turnaround
// guard, internal loopback and shared drive-strength select.
module n101_spigpioport_sync #(
   parameter int DQ_W        = 4,
   parameter int CS_W        = 1,
   parameter int SYNC_STAGES = 2,
   parameter int TURN_CYC    = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_spi_sck,
   input  logic [DQ_W-1:0] io_spi_dq_o,
   input  logic [DQ_W-1:0] io_spi_dq_oe,
   output logic [DQ_W-1:0] io_spi_dq_i,
   input  logic [CS_W-1:0] io_spi_cs,
   input  logic            io_loopback,
   input  logic            io_ds_cfg,
   output logic [DQ_W-1:0] io_turn_busy,
   input  logic            io_pins_sck_i_ival,
   output logic            io_pins_sck_o_oval,
   output logic            io_pins_sck_o_oe,
   output logic            io_pins_sck_o_ie,
   output logic            io_pins_sck_o_pue,
   output logic            io_pins_sck_o_ds,
   input  logic [DQ_W-1:0] io_pins_dq_i_ival,
   output logic [DQ_W-1:0] io_pins_dq_o_oval,
   output logic [DQ_W-1:0] io_pins_dq_o_oe,
   output logic [DQ_W-1:0] io_pins_dq_o_ie,
   output logic [DQ_W-1:0] io_pins_dq_o_pue,
   output logic [DQ_W-1:0] io_pins_dq_o_ds,
   input  logic [CS_W-1:0] io_pins_cs_i_ival,
   output logic [CS_W-1:0] io_pins_cs_o_oval,
   output logic [CS_W-1:0] io_pins_cs_o_oe,
   output logic [CS_W-1:0] io_pins_cs_o_ie,
   output logic [CS_W-1:0] io_pins_cs_o_pue,
   output logic [CS_W-1:0] io_pins_cs_o_ds
);

   localparam logic [1:0] ST_RECV  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;
   localparam int         CNT_W    = 4;
   localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

   logic [DQ_W-1:0] sync_src;
   logic [CS_W-1:0] cs_p0;
   logic            unused_pads;

   // SCK and CS pad inputs are never sampled; pads are output-only here.
   assign unused_pads = ^{io_pins_sck_i_ival, io_pins_cs_i_ival};

   assign sync_src = io_loopback ? io_spi_dq_o : io_pins_dq_i_ival;

   assign io_pins_sck_o_oval = io_spi_sck;
   assign io_pins_sck_o_oe   = ~io_loopback;
   assign io_pins_sck_o_ie   = 1'b0;
   assign io_pins_sck_o_pue  = 1'b0;
   assign io_pins_sck_o_ds   = io_ds_cfg;

   // Stage p0: chip selects registered, idle high so the device is deselected.
   always_ff @(posedge clock) begin
      if (reset) begin
         cs_p0 <= '1;
      end else begin
         cs_p0 <= io_spi_cs;
      end
   end

   assign io_pins_cs_o_oval = cs_p0;
   assign io_pins_cs_o_oe   = '1;
   assign io_pins_cs_o_ie   = '0;
   assign io_pins_cs_o_pue  = '1;
   assign io_pins_cs_o_ds   = {CS_W{io_ds_cfg}};

   assign io_pins_dq_o_oval = io_spi_dq_o;
   assign io_pins_dq_o_oe   = io_spi_dq_oe & ~{DQ_W{io_loopback}};
   assign io_pins_dq_o_ds   = {DQ_W{io_ds_cfg}};

   for (genvar n = 0; n < DQ_W; n++) begin : g_lane
      logic [1:0]       state;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clock) begin
         if (reset) begin
            state <= ST_RECV;
            cnt   <= '0;
         end else begin
            case (state)
               ST_RECV: begin
                  if (io_spi_dq_oe[n]) state <= ST_DRIVE;
               end
               ST_DRIVE: begin
                  if (!io_spi_dq_oe[n]) begin
                     state <= ST_TURN;
                     cnt   <= TURN_LOAD;
                  end
               end
               ST_TURN: begin
                  // A renewed drive aborts the guard; otherwise count it out.
                  if (io_spi_dq_oe[n]) begin
                     state <= ST_DRIVE;
                     cnt   <= '0;
                  end else if (cnt == '0) begin
                     state <= ST_RECV;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: begin
                  state <= ST_RECV;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign io_turn_busy[n]     = (state == ST_TURN);
      assign io_pins_dq_o_ie[n]  = (state == ST_RECV) & ~io_loopback;
      assign io_pins_dq_o_pue[n] = (state != ST_DRIVE);

      if (SYNC_STAGES == 0) begin : g_pass
         logic hold_p0;

         // Stage p0: holds the last pre-guard value so TURN can freeze the lane.
         always_ff @(posedge clock) begin
            if (reset) begin
               hold_p0 <= 1'b0;
            end else if (state != ST_TURN) begin
               hold_p0 <= sync_src[n];
            end
         end

         assign io_spi_dq_i[n] = (state == ST_TURN) ? hold_p0 : sync_src[n];
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_p;

         // Stages p0..pN: shift chain; the final stage freezes during TURN.
         always_ff @(posedge clock) begin
            if (reset) begin
               sync_p <= '0;
            end else begin
               sync_p <= SYNC_STAGES'({sync_p, sync_src[n]});
               if (state == ST_TURN) sync_p[SYNC_STAGES-1] <= sync_p[SYNC_STAGES-1];
            end
         end

         assign io_spi_dq_i[n] = sync_p[SYNC_STAGES-1];
      end
   end

endmodule

// File: doc/n101_spigpioport_sync.md
Name: n101_spigpioport_sync

Overview:
- Parametrised SPI-to-GPIO pad port with DQ_W data lanes and CS_W chip selects.
- Sits between the SPI controller and the GPIO pad mux.
- Adds the following over a plain pad wiring:
  - synchronisers on the input path;
  - a per-lane bus-turnaround guard state machine;
  - an internal loopback mode;
  - a configurable drive strength.

Parameters:
DQ_W, 4, number of DQ lanes (1..8)
CS_W, 1, number of chip selects (1..4)
SYNC_STAGES, 2, input synchroniser depth (0 = pass-through, 1..3)
TURN_CYC, 2, guard cycles after a lane stops driving (1..15)

Ports:
clock  in  1  core clock
reset  in  1  synchronous reset, active-high
io_spi_sck  in  1  controller SCK
io_spi_dq_o  in  DQ_W  controller DQ output value
io_spi_dq_oe  in  DQ_W  controller DQ output enable
io_spi_dq_i  out  DQ_W  synchronised DQ input to controller
io_spi_cs  in  CS_W  controller chip selects (active-low)
io_loopback  in  1  1 = internal loopback, pins tristated
io_ds_cfg  in  1  drive-strength select for SCK/DQ/CS pins
io_turn_busy  out  DQ_W  lane currently in TURN state
io_pins_sck_i_ival  in  1  unused pad input
io_pins_sck_o_oval/oe/ie/pue/ds  out  1 each  SCK pad controls
io_pins_dq_i_ival  in  DQ_W  DQ pad inputs
io_pins_dq_o_oval/oe/ie/pue/ds  out  DQ_W each  DQ pad controls
io_pins_cs_i_ival  in  CS_W  unused pad inputs
io_pins_cs_o_oval/oe/ie/pue/ds  out  CS_W each  CS pad controls

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous, active-high, and sampled on the rising edge.
- SCK pad:
  - oval = io_spi_sck, combinational.
  - oe = ~io_loopback.
  - ie = 0, pue = 0, ds = io_ds_cfg.
- CS pads:
  - oval = registered io_spi_cs (1 cycle latency); reset value all-ones (deasserted).
  - oe = 1 always, including in loopback, so the device is never selected floating.
  - ie = 0, pue = 1, ds = io_ds_cfg.
- Input synchroniser, per lane:
  - Source is io_pins_dq_i_ival[n]; when io_loopback = 1 the source is io_spi_dq_o[n].
  - SYNC_STAGES flops, all reset to 0.
  - io_spi_dq_i[n] = last stage, so latency is SYNC_STAGES cycles.
  - SYNC_STAGES = 0: combinational pass-through.
  - Changing io_loopback does not flush the chain; stale bits drain naturally.
- Turnaround FSM, per lane, with states DRIVE, TURN, RECV:
  - Reset: state = RECV, counter = 0.
  - RECV, oe = 1: go to DRIVE next cycle.
  - DRIVE, oe = 0: go to TURN, counter loaded with TURN_CYC-1.
  - TURN, oe = 1: go to DRIVE immediately; the counter is cleared.
  - TURN, oe = 0: decrement the counter; go to RECV when counter = 0 and oe = 0.
  - TURN therefore lasts exactly TURN_CYC cycles when uninterrupted.
  - io_turn_busy[n] = (state == TURN).
- DQ pad outputs:
  - oval = io_spi_dq_o[n], combinational.
  - oe = io_spi_dq_oe[n] & ~io_loopback, combinational. The guard never delays a controller drive.
  - ie = (state == RECV) & ~io_loopback.
  - pue = 1 when state != DRIVE, else 0.
  - ds = io_ds_cfg.
- Hold during guard: while a lane is in TURN, io_spi_dq_i[n] holds its value from the cycle TURN was entered. The synchroniser last stage is frozen for that lane.
- Reset output values:
  - io_spi_dq_i = 0, io_turn_busy = 0, dq ie = ~io_loopback.
  - dq oe follows the inputs; cs oval = all-ones.
- Reset mid-operation: any lane in TURN or DRIVE returns to RECV on the next edge.
- Lanes are fully independent; simultaneous events on different lanes do not interact.

Test Plan:
1. Reset release, DQ_W=4, SYNC_STAGES=2, all oe=0, pins=4'b1010 → io_spi_dq_i=0 for 2 cycles, then 4'b1010; io_pins_dq_o_ie=4'b1111; io_turn_busy=0.
2. Lane 0: oe=1 for 3 cycles, then 0, TURN_CYC=2:
   - io_turn_busy[0]=1 for exactly 2 cycles, then ie[0]=1 and pue[0]=1 throughout;
   - io_spi_dq_i[0] frozen during TURN; ie[3:1] unaffected.
3. Lane 1: oe falls, then rises again after 1 cycle of TURN → DRIVE next cycle; busy[1] drops; oe pad follows combinationally; a later fall restarts a full 2-cycle TURN.
4. io_loopback=1, dq_o=4'b0110, pins=4'b1001:
   - io_spi_dq_i=4'b0110 after 2 cycles;
   - dq oe=0, dq ie=0, sck oe=0, cs oe=1.
5. io_spi_cs toggles 1→0→1:
   - cs_o_oval follows 1 cycle later;
   - reset asserted mid-transfer forces cs_o_oval=1 and all lanes to RECV on the next edge.
6. SYNC_STAGES=0, TURN_CYC=1, io_ds_cfg=1:
   - io_spi_dq_i equals pins the same cycle;
   - TURN lasts 1 cycle;
   - all ds outputs = 1.
